lcd_cmd_sequencer: RTL and testbench

LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_delay_counter.sv | 31 +++
 rtl/lcd_cmd_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: state encoding, init ROM and limits.
// The POLL state and read-phase encoding exist only when LCD_SEQ_BUSY_POLL_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_LOAD,
        ST_IDLE,
        ST_STROBE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
`ifdef LCD_SEQ_BUSY_POLL_EN
        ST_POLL
`else
        ST_SETTLE
`endif
    } lcd_state_e;

`ifdef LCD_SEQ_BUSY_POLL_EN
    localparam lcd_state_e ST_POST = ST_POLL;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_LOW,
        PH_HIGH
    } lcd_poll_ph_e;

    localparam int POLL_LIMIT = 4096;
    localparam int POLL_W     = 12;
`else
    localparam lcd_state_e ST_POST = ST_SETTLE;
`endif

    localparam logic [7:0] INIT_CMD0  = 8'h38;
    localparam logic [7:0] INIT_CMD1  = 8'h0C;
    localparam logic [7:0] INIT_CMD2  = 8'h01;
    localparam logic [7:0] INIT_CMD3  = 8'h06;
    localparam int         INIT_LEN   = 4;
    localparam int         WDOG_LIMIT = 64;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_CMD0;
            2'd1:    return INIT_CMD1;
            2'd2:    return INIT_CMD2;
            default: return INIT_CMD3;
        endcase
    endfunction

    // Clear and home commands need the long settle time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Saturating down-counter: i_start loads i_load, o_done flags the terminal count.
module lcd_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_load,
    output logic         o_done,
    output logic         o_busy
);
    logic [W-1:0] r_cnt;
    logic         r_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= i_load;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else             r_run <= 1'b0;
        end
    end

    assign o_done = r_run && (r_cnt == '0);
    assign o_busy = r_run;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// LCD command sequencer: power-up wait, fixed init ROM, then host bytes to the LCD timing controller.
// Define LCD_SEQ_BUSY_POLL_EN to replace the fixed post-command delay with busy-flag polling.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int INIT_WAIT = 750000,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       ack,
    output logic       init_done,
    output logic       nCS,
    output logic       nWR,
    output logic       nRD,
    output logic       RS,
    output logic [7:0] DB_out,
    output logic       DB_oe,
    input  logic [7:0] DB_in,
    input  logic       RDY
);
    // state      | meaning
    // PWR_WAIT   | power-up delay after reset
    // INIT_LOAD  | fetch next init ROM byte
    // IDLE       | accept host request once init is done
    // STROBE     | assert nCS/nWR with the latched byte
    // WAIT_LOW   | wait for RDY low, bounded by the watchdog
    // WAIT_HIGH  | strobes released, wait for RDY high
    // SETTLE     | fixed post-command delay
    // POLL       | busy-flag read loop (busy-poll build only)

    localparam int CNT_MAX0 = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int CNT_MAX  = (CNT_MAX0 > CMD_WAIT) ? CNT_MAX0 : CMD_WAIT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int IDX_W    = $clog2(INIT_LEN);
    localparam int WDOG_W   = $clog2(WDOG_LIMIT);

    lcd_state_e        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_init_done;
    logic              r_ack;
    logic              r_ncs;
    logic              r_nwr;
    logic              r_rs;
    logic [7:0]        r_db;
    logic              r_oe;
    logic              r_lat_rs;
    logic [7:0]        r_lat_data;
    logic [WDOG_W-1:0] r_wdog;

    logic              w_dly_start;
    logic [CNT_W-1:0]  w_dly_load;
    logic              w_dly_done;
    logic              w_dly_busy;
    logic              w_wdog_max;
    logic              w_last_init;
    lcd_state_e        w_after_state;

    assign w_wdog_max    = (r_wdog == WDOG_W'(WDOG_LIMIT - 1));
    assign w_last_init   = (r_idx == IDX_W'(INIT_LEN - 1));
    assign w_after_state = (r_init_done || w_last_init) ? ST_IDLE : ST_INIT_LOAD;

    always_comb begin
        w_dly_start = (r_state == ST_PWR_WAIT) && !w_dly_busy;
        w_dly_load  = CNT_W'(INIT_WAIT);
`ifndef LCD_SEQ_BUSY_POLL_EN
        if ((r_state == ST_WAIT_HIGH && RDY) ||
            (r_state == ST_WAIT_LOW && RDY && w_wdog_max)) begin
            w_dly_start = 1'b1;
            w_dly_load  = is_long_cmd(r_rs, r_db) ? CNT_W'(CLR_WAIT) : CNT_W'(CMD_WAIT);
        end
`endif
    end

    lcd_delay_counter #(.W(CNT_W)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_dly_start),
        .i_load  (w_dly_load),
        .o_done  (w_dly_done),
        .o_busy  (w_dly_busy)
    );

`ifdef LCD_SEQ_BUSY_POLL_EN
    lcd_poll_ph_e      r_poll_ph;
    logic [POLL_W-1:0] r_poll_cnt;
    logic              r_nrd;
    assign nRD = r_nrd;
`else
    logic w_unused_db;
    assign w_unused_db = ^DB_in;
    assign nRD = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PWR_WAIT;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_ack       <= 1'b0;
            r_ncs       <= 1'b1;
            r_nwr       <= 1'b1;
            r_rs        <= 1'b0;
            r_db        <= 8'h00;
            r_oe        <= 1'b0;
            r_lat_rs    <= 1'b0;
            r_lat_data  <= 8'h00;
            r_wdog      <= '0;
`ifdef LCD_SEQ_BUSY_POLL_EN
            r_poll_ph   <= PH_ISSUE;
            r_poll_cnt  <= '0;
            r_nrd       <= 1'b1;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_PWR_WAIT: if (w_dly_done) r_state <= ST_INIT_LOAD;
                ST_INIT_LOAD: begin
                    r_lat_rs   <= 1'b0;
                    r_lat_data <= init_rom(r_idx);
                    r_state    <= ST_STROBE;
                end
                ST_IDLE: if (req && r_init_done) begin
                    r_lat_rs   <= req_rs;
                    r_lat_data <= req_data;
                    r_ack      <= 1'b1;
                    r_state    <= ST_STROBE;
                end
                ST_STROBE: begin
                    r_ncs   <= 1'b0;
                    r_nwr   <= 1'b0;
                    r_rs    <= r_lat_rs;
                    r_db    <= r_lat_data;
                    r_oe    <= 1'b1;
                    r_wdog  <= '0;
                    r_state <= ST_WAIT_LOW;
`ifdef LCD_SEQ_BUSY_POLL_EN
                    r_poll_ph  <= PH_ISSUE;
                    r_poll_cnt <= '0;
`endif
                end
                ST_WAIT_LOW: begin
                    // A stuck-high RDY is treated as a completed write.
                    if (!RDY || w_wdog_max) begin
                        r_ncs   <= 1'b1;
                        r_nwr   <= 1'b1;
                        r_state <= RDY ? ST_POST : ST_WAIT_HIGH;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_WAIT_HIGH: if (RDY) r_state <= ST_POST;
`ifdef LCD_SEQ_BUSY_POLL_EN
                ST_POLL: begin
                    case (r_poll_ph)
                        PH_ISSUE: begin
                            r_ncs     <= 1'b0;
                            r_nrd     <= 1'b0;
                            r_rs      <= 1'b0;
                            r_oe      <= 1'b0;
                            r_wdog    <= '0;
                            r_poll_ph <= PH_LOW;
                        end
                        PH_LOW: begin
                            if (!RDY || w_wdog_max) begin
                                r_ncs     <= 1'b1;
                                r_nrd     <= 1'b1;
                                r_poll_ph <= PH_HIGH;
                            end else begin
                                r_wdog <= r_wdog + 1'b1;
                            end
                        end
                        PH_HIGH: if (RDY) begin
                            if (!DB_in[7] || r_poll_cnt == POLL_W'(POLL_LIMIT - 1)) begin
                                r_state <= w_after_state;
                                if (!r_init_done) begin
                                    if (w_last_init) r_init_done <= 1'b1;
                                    else             r_idx <= r_idx + 1'b1;
                                end
                            end else begin
                                r_poll_cnt <= r_poll_cnt + 1'b1;
                                r_poll_ph  <= PH_ISSUE;
                            end
                        end
                        default: r_poll_ph <= PH_ISSUE;
                    endcase
                end
`else
                ST_SETTLE: if (w_dly_done) begin
                    r_state <= w_after_state;
                    if (!r_init_done) begin
                        if (w_last_init) r_init_done <= 1'b1;
                        else             r_idx <= r_idx + 1'b1;
                    end
                end
`endif
                default: r_state <= ST_PWR_WAIT;
            endcase
        end
    end

    assign ack       = r_ack;
    assign init_done = r_init_done;
    assign nCS       = r_ncs;
    assign nWR       = r_nwr;
    assign RS        = r_rs;
    assign DB_out    = r_db;
    assign DB_oe     = r_oe;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Randomized bench for lcd_cmd_sequencer: a transaction monitor is compared against a
// spec-level expectation list (byte order, init_done state, settle gaps or poll read counts).
module tb_lcd_cmd_sequencer;
    localparam int INIT_WAIT = 20;
    localparam int CMD_WAIT  = 5;
    localparam int CLR_WAIT  = 12;
    localparam int GAP_SLACK = 8;

    typedef enum int {K_NORMAL, K_WDOG, K_ABANDON} kind_e;
    typedef struct { logic idn; logic rs; logic [7:0] db; kind_e kind; } exp_t;
    typedef struct { logic idn; logic rs; logic [7:0] db; logic oe; int gap; int reads; } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic [7:0] DB_in = 8'h00;
    logic       RDY = 1'b1;
    logic       ack, init_done, nCS, nWR, nRD, RS, DB_oe;
    logic [7:0] DB_out;

    lcd_cmd_sequencer #(
        .INIT_WAIT (INIT_WAIT),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .ack       (ack),
        .init_done (init_done),
        .nCS       (nCS),
        .nWR       (nWR),
        .nRD       (nRD),
        .RS        (RS),
        .DB_out    (DB_out),
        .DB_oe     (DB_oe),
        .DB_in     (DB_in),
        .RDY       (RDY)
    );

    initial forever #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_acks = 0;
    int   n_writes = 0;
    int   nrd_lows = 0;
    int   reads = 0;
    int   last_rise = 0;
    int   fall_cyc = 0;
    int   low_len = 0;
    bit   rdy_tied = 1'b0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    localparam logic [13:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int settle_of(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLR_WAIT : CMD_WAIT;
    endfunction

    initial forever @(posedge clk) cyc++;

    // LCD timing controller: RDY drops for 3 cycles after each strobe unless tied high.
    initial begin : rdy_model
        int   cnt;
        logic prev;
        cnt  = 0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) RDY = 1'b1;
            end else if (!rdy_tied && prev && !nCS) begin
                RDY = 1'b0;
                cnt = 3;
            end
            prev = nCS;
        end
    end

    // Records every write with its gap from the previous release (or reset) and the
    // number of busy reads that preceded it; busy flag is set for the first 3 reads.
    initial begin : monitor
        logic p_ncs, p_nwr, p_nrd;
        p_ncs = 1'b1; p_nwr = 1'b1; p_nrd = 1'b1;
        forever begin
            @(negedge clk);
            if (ack) n_acks++;
            if (!nRD) nrd_lows++;
            if (p_nwr && !nWR) begin
                obs_q.push_back('{init_done, RS, DB_out, DB_oe, cyc - last_rise, reads});
                reads = 0;
            end
            if (p_nrd && !nRD) reads++;
            DB_in = (reads <= 3) ? 8'h80 : 8'h00;
            if (p_ncs && !nCS) fall_cyc = cyc;
            if (!p_ncs && nCS) begin
                last_rise = cyc;
                low_len   = cyc - fall_cyc;
            end
            if (rst) last_rise = cyc;
            p_ncs = nCS; p_nwr = nWR; p_nrd = nRD;
        end
    end

    task automatic push_rom();
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 1'b0, rom[i], K_NORMAL});
    endtask

    task automatic host_write(input logic rs, input logic [7:0] d, input kind_e kind);
        bit got;
        got = 1'b0;
        req = 1'b1; req_rs = rs; req_data = d;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        req = 1'b0;
        if (got) begin
            exp_q.push_back('{1'b1, rs, d, kind});
            n_writes++;
            chk("ack_after_init", {31'd0, init_done}, 32'd1);
            @(negedge clk);
            chk("ack_width", {31'd0, ack}, 32'd0);
            chk("strobe_next_cycle", {nCS, nWR, RS, DB_oe, DB_out}, {1'b0, 1'b0, rs, 1'b1, d});
        end
    endtask

    task automatic rand_write(input kind_e kind);
        logic       rs;
        logic [7:0] d;
        rs = 1'($urandom_range(0, 1));
        if (!rs && $urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
        else                                  d = 8'($urandom);
        host_write(rs, d, kind);
    endtask

    initial begin : watchdog_timer
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        bit rose;
        repeat (3) @(negedge clk);
        chk("reset_state", {ack, init_done, nCS, nWR, nRD, RS, DB_oe, DB_out}, RST_VEC);
        push_rom();
        rst = 1'b0;

        host_write(1'b1, 8'h41, K_NORMAL);
        repeat (12) rand_write(K_NORMAL);

        rdy_tied = 1'b1;
        rand_write(K_WDOG);
        rose = 1'b0;
        for (int i = 0; i < 200 && !rose; i++) begin
            @(negedge clk);
            if (nCS) rose = 1'b1;
        end
        @(negedge clk);
        chk("wdog_release", {31'd0, rose}, 32'd1);
        chk("wdog_low_len", low_len, WDOG_LEN());
        rdy_tied = 1'b0;
        rand_write(K_NORMAL);

        rand_write(K_ABANDON);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_strobe", {ack, init_done, nCS, nWR, nRD, RS, DB_oe, DB_out}, RST_VEC);
        push_rom();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) rand_write(K_NORMAL);
        repeat (80) @(negedge clk);

        chk("entry_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("entry%0d", i),
                {obs_q[i].idn, obs_q[i].rs, obs_q[i].db, obs_q[i].oe},
                {exp_q[i].idn, exp_q[i].rs, exp_q[i].db, 1'b1});
`ifdef LCD_SEQ_BUSY_POLL_EN
            if (i > 0 && exp_q[i-1].kind != K_ABANDON)
                chk($sformatf("reads%0d", i), obs_q[i].reads, 4);
`else
            begin
                int lo;
                if (i == 0 || exp_q[i-1].kind == K_ABANDON) lo = INIT_WAIT;
                else lo = settle_of(exp_q[i-1].rs, exp_q[i-1].db);
                chk($sformatf("gap%0d_%0d", i, obs_q[i].gap),
                    {31'd0, (obs_q[i].gap >= lo) && (obs_q[i].gap <= lo + GAP_SLACK)}, 32'd1);
            end
`endif
        end
`ifdef LCD_SEQ_BUSY_POLL_EN
        chk("last_reads", reads, 4);
`else
        chk("nrd_idle", nrd_lows, 0);
`endif
        chk("ack_count", n_acks, n_writes);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    function automatic int WDOG_LEN();
        return 64;
    endfunction

endmodule
